vc_tx_scheduler: RTL

Weighted round-robin scheduler that drains the four per-class transaction FIFOs into the shared mux and output FIFO path. Each cycle it may pop at most one source FIFO, and only if that FIFO is non-empty and the destination FIFO selected by its head-of-line class is not almost full. It is gated by the state machine's active state. It replaces ad-hoc pop generation with a single owner of the shared datapath.

---
 rtl/vc_tx_scheduler_if.sv | 31 +++
 rtl/vc_tx_scheduler.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/vc_tx_scheduler_if.sv
// Handshake bundle between the per-class source FIFOs, the destination
// FIFO flags and vc_tx_scheduler.
interface vc_tx_scheduler_if #(
    parameter int WW = 3
);
    logic          enable;
    logic [3:0]    empty;
    logic [7:0]    dest_class;
    logic [3:0]    dst_alm_full;
    logic [WW-1:0] weight0;
    logic [WW-1:0] weight1;
    logic [WW-1:0] weight2;
    logic [WW-1:0] weight3;
    logic [3:0]    pop;
    logic          push;
    logic [1:0]    grant_idx;
    logic          busy;
    logic          idle;

    modport master (
        output enable, empty, dest_class, dst_alm_full,
        output weight0, weight1, weight2, weight3,
        input  pop, push, grant_idx, busy, idle
    );

    modport slave (
        input  enable, empty, dest_class, dst_alm_full,
        input  weight0, weight1, weight2, weight3,
        output pop, push, grant_idx, busy, idle
    );
endinterface

// File: rtl/vc_tx_scheduler.sv
// Weighted round-robin drain of four class FIFOs into the shared output path.
// Define VC_SCHED_WRR_EN to load burst lengths from weight0..3; otherwise every burst is one pop.
module vc_tx_scheduler #(
    parameter int WW = 3
) (
    input  logic             clk,
    input  logic             reset,
    vc_tx_scheduler_if.slave sched
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [WW-1:0] ONE_W  = WW'(1'b1);
    localparam logic [WW-1:0] ZERO_W = {WW{1'b0}};

    logic [1:0]    state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [WW-1:0] cnt_q, cnt_d;
    logic [1:0]    grant_q, grant_d;
    logic          push_q;

    logic [3:0]    elig_s;
    logic [3:0]    rot_s;
    logic [1:0]    off_s;
    logic [1:0]    pick_s;
    logic          found_s;
    logic [3:0]    pop_s;
    logic [WW-1:0] load_w_s;

    // A source is eligible when it has data and its head-of-line destination can accept it.
    always_comb begin
        elig_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            elig_s[i] = !sched.empty[i] && !sched.dst_alm_full[sched.dest_class[2*i +: 2]];
        end
    end

    // Rotate eligibility so that bit 0 corresponds to the search start ptr_q.
    always_comb begin
        case (ptr_q)
            2'd0:    rot_s = elig_s;
            2'd1:    rot_s = {elig_s[0],   elig_s[3:1]};
            2'd2:    rot_s = {elig_s[1:0], elig_s[3:2]};
            2'd3:    rot_s = {elig_s[2:0], elig_s[3]};
            default: rot_s = elig_s;
        endcase
    end

    // First eligible offset from ptr_q.
    always_comb begin
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
    end

    assign found_s = |elig_s;
    assign pick_s  = ptr_q + off_s;

`ifdef VC_SCHED_WRR_EN
    function automatic logic [WW-1:0] eff_weight(input logic [WW-1:0] w);
        logic [WW-1:0] r;
        r = (w == ZERO_W) ? ONE_W : w;
        return r;
    endfunction

    // Burst length of the candidate source.
    always_comb begin
        case (pick_s)
            2'd0:    load_w_s = eff_weight(sched.weight0);
            2'd1:    load_w_s = eff_weight(sched.weight1);
            2'd2:    load_w_s = eff_weight(sched.weight2);
            2'd3:    load_w_s = eff_weight(sched.weight3);
            default: load_w_s = ONE_W;
        endcase
    end
`else
    assign load_w_s = ONE_W;
`endif

    // Pop is combinational from state so it drops in the very cycle enable falls or an eligibility is lost.
    always_comb begin
        pop_s = 4'b0000;
        if ((state_q == ST_BURST) && sched.enable && elig_s[grant_q]) begin
            pop_s[grant_q] = 1'b1;
        end else begin
            pop_s = 4'b0000;
        end
    end

    // Scheduler next-state: disable dominates, a burst ends on its last pop or when its source stalls.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        if (!sched.enable) begin
            state_d = ST_IDLE;
            cnt_d   = ZERO_W;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARB;
                end
                ST_ARB: begin
                    if (found_s) begin
                        grant_d = pick_s;
                        cnt_d   = load_w_s;
                        state_d = ST_BURST;
                    end else begin
                        state_d = ST_ARB;
                    end
                end
                ST_BURST: begin
                    if (!elig_s[grant_q]) begin
                        state_d = ST_ARB;
                        ptr_d   = grant_q + 2'd1;
                    end else if (cnt_q <= ONE_W) begin
                        state_d = ST_ARB;
                        ptr_d   = grant_q + 2'd1;
                        cnt_d   = ZERO_W;
                    end else begin
                        cnt_d   = cnt_q - ONE_W;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = ZERO_W;
                end
            endcase
        end
    end

    // State registers; push lags pop by one cycle to match the source FIFO read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= ZERO_W;
            grant_q <= 2'd0;
            push_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            push_q  <= |pop_s;
        end
    end

    assign sched.pop       = pop_s;
    assign sched.push      = push_q;
    assign sched.grant_idx = grant_q;
    assign sched.busy      = (state_q == ST_BURST);
    assign sched.idle      = (&sched.empty) && (state_q != ST_BURST);
endmodule
